// File: rtl/a2i7seg_pkg.sv
// rtl/a2i7seg_pkg.sv - segment constants, code width and FSM states for the A..I receiver
package a2i7seg_pkg;

  localparam int CODE_W = 4;

  // Active-low patterns, bit 6 = g ... bit 0 = a
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_G     = 7'b0010000;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_I     = 7'b1111001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

endpackage

// File: rtl/a2i7seg_dec.sv
// rtl/a2i7seg_dec.sv - combinational 7-segment pattern to letter code decoder
module a2i7seg_dec
  import a2i7seg_pkg::*;
(
  input  logic [6:0]        seg,
  output logic              hit,
  output logic [CODE_W-1:0] code
);

  always_comb begin
    hit  = 1'b1;
    code = '0;
    unique case (seg)
      SEG_A:   code = 4'd0;
      SEG_B:   code = 4'd1;
      SEG_C:   code = 4'd2;
      SEG_D:   code = 4'd3;
      SEG_E:   code = 4'd4;
      SEG_F:   code = 4'd5;
      SEG_G:   code = 4'd6;
      SEG_H:   code = 4'd7;
      SEG_I:   code = 4'd8;
      default: hit  = 1'b0;
    endcase
  end

endmodule

// File: rtl/a2i7seg_rx.sv
// rtl/a2i7seg_rx.sv - stability-filtered 7-segment letter receiver with valid/ready output
// Optional saturating error counter port enabled by A2I7SEG_RX_ERRCNT_EN.
module a2i7seg_rx
  import a2i7seg_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [6:0]        seg_i,
  input  logic              ready_i,
  output logic [CODE_W-1:0] code_o,
  output logic              valid_o,
  output logic              err_o
`ifdef A2I7SEG_RX_ERRCNT_EN
  ,
  output logic [7:0]        err_cnt_o
`endif
);

  logic [6:0]        seg_q;
  logic [6:0]        last_q;
  logic [6:0]        last_d;
  logic [3:0]        run_cnt;
  logic [CODE_W-1:0] code_d;
  logic [CODE_W-1:0] dec_code;
  logic              dec_hit;
  logic              valid_d;
  logic              err_d;
  logic              accept;
  logic              is_blank;
  state_t            state_q;
  state_t            state_d;

  a2i7seg_dec u_dec (
    .seg  (seg_q),
    .hit  (dec_hit),
    .code (dec_code)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      seg_q   <= SEG_BLANK;
      run_cnt <= '0;
    end else begin
      seg_q <= seg_i;
      if (seg_i != seg_q) begin
        run_cnt <= 4'd1;
      end else if (run_cnt != 4'(STABLE_CNT)) begin
        run_cnt <= run_cnt + 4'd1;
      end
    end
  end

  assign accept   = (run_cnt == 4'(STABLE_CNT)) && (seg_q != last_q);
  assign is_blank = (seg_q == SEG_BLANK);

  always_comb begin
    state_d = state_q;
    code_d  = code_o;
    valid_d = valid_o;
    last_d  = last_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          last_d = seg_q;
          if (dec_hit) begin
            code_d  = dec_code;
            valid_d = 1'b1;
            state_d = HOLD;
          end else if (!is_blank) begin
            err_d = 1'b1;
          end
        end
      end
      HOLD: begin
        // Handshake completes; a stable new pattern in the same cycle is taken as in IDLE
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
          if (accept) begin
            last_d = seg_q;
            if (dec_hit) begin
              code_d  = dec_code;
              valid_d = 1'b1;
              state_d = HOLD;
            end else if (!is_blank) begin
              err_d = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      code_o  <= '0;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      last_q  <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      code_o  <= code_d;
      valid_o <= valid_d;
      err_o   <= err_d;
      last_q  <= last_d;
    end
  end

`ifdef A2I7SEG_RX_ERRCNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_cnt_o <= '0;
    end else if (err_d && (err_cnt_o != 8'hFF)) begin
      err_cnt_o <= err_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_a2i7seg_rx.sv
// tb/tb_a2i7seg_rx.sv - directed self-checking bench for a2i7seg_rx (STABLE_CNT = 4)
module tb_a2i7seg_rx;
  import a2i7seg_pkg::*;

  logic       clk;
  logic       rst_ni;
  logic [6:0] seg_i;
  logic       ready_i;
  logic [3:0] code_o;
  logic       valid_o;
  logic       err_o;
`ifdef A2I7SEG_RX_ERRCNT_EN
  logic [7:0] err_cnt_o;
`endif

  int checks;
  int errors;

  a2i7seg_rx #(.STABLE_CNT(4)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .seg_i     (seg_i),
    .ready_i   (ready_i),
    .code_o    (code_o),
    .valid_o   (valid_o),
    .err_o     (err_o)
`ifdef A2I7SEG_RX_ERRCNT_EN
    ,
    .err_cnt_o (err_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ni  = 1'b0;
    seg_i   = SEG_BLANK;
    ready_i = 1'b0;
    tick();
    tick();
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
    checks++;
    if (code_o !== 4'd0) begin errors++; $display("FAIL reset_code got %0d want 0", code_o); end
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_o); end
`ifdef A2I7SEG_RX_ERRCNT_EN
    checks++;
    if (err_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_errcnt got %0d want 0", err_cnt_o); end
`endif
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_letter_a();
    int early;
    int late_low;
    early = 0;
    late_low = 0;
    seg_i = SEG_A;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (valid_o) early++;
    end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL a_latency_early got %0d valid cycles want 0", early); end
    tick();
    checks++;
    if (valid_o !== 1'b1) begin errors++; $display("FAIL a_valid got %b want 1", valid_o); end
    checks++;
    if (code_o !== 4'd0) begin errors++; $display("FAIL a_code got %0d want 0", code_o); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!valid_o) late_low++;
    end
    checks++;
    if (late_low !== 0) begin errors++; $display("FAIL a_hold got %0d low cycles want 0", late_low); end
    ready_i = 1'b1;
    tick();
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL a_release got %b want 0", valid_o); end
    early = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valid_o) early++;
    end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL a_no_redeliver got %0d valid cycles want 0", early); end
    ready_i = 1'b0;
  endtask

  task automatic test_unstable();
    int seen;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      seg_i = (i % 2 == 0) ? SEG_B : SEG_C;
      tick();
      if (valid_o || err_o) seen++;
      tick();
      if (valid_o || err_o) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL unstable got %0d active cycles want 0", seen); end
  endtask

  task automatic hold_count_h(input logic [6:0] pat, input int n, inout int deliveries);
    seg_i = pat;
    for (int i = 0; i < n; i++) begin
      tick();
      if (valid_o && code_o == 4'd7) deliveries++;
    end
  endtask

  task automatic test_rearm();
    int dlv;
    dlv = 0;
    ready_i = 1'b1;
    hold_count_h(SEG_H, 6, dlv);
    hold_count_h(SEG_BLANK, 6, dlv);
    hold_count_h(SEG_H, 6, dlv);
    checks++;
    if (dlv !== 2) begin errors++; $display("FAIL rearm_h got %0d deliveries want 2", dlv); end
    dlv = 0;
    hold_count_h(7'b0000000, 1, dlv);
    hold_count_h(SEG_H, 8, dlv);
    checks++;
    if (dlv !== 0) begin errors++; $display("FAIL h_h_no_blank got %0d deliveries want 0", dlv); end
    ready_i = 1'b0;
  endtask

  task automatic test_error();
    int pulses;
    int vseen;
    logic at5;
    pulses = 0;
    vseen = 0;
    at5 = 1'b0;
    seg_i = 7'b1010101;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (err_o) pulses++;
      if (valid_o) vseen++;
      if (i == 5) at5 = err_o;
    end
    checks++;
    if (at5 !== 1'b1) begin errors++; $display("FAIL err_latency got %b want 1", at5); end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL err_pulses got %0d want 1", pulses); end
    checks++;
    if (vseen !== 0) begin errors++; $display("FAIL err_valid got %0d valid cycles want 0", vseen); end
`ifdef A2I7SEG_RX_ERRCNT_EN
    checks++;
    if (err_cnt_o !== 8'd1) begin errors++; $display("FAIL err_cnt_one got %0d want 1", err_cnt_o); end
`endif
  endtask

  task automatic test_back_to_back();
    int drop;
    drop = 0;
    ready_i = 1'b0;
    seg_i = SEG_E;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (valid_o !== 1'b1 || code_o !== 4'd4) begin
      errors++; $display("FAIL b2b_first got valid=%b code=%0d want valid=1 code=4", valid_o, code_o);
    end
    seg_i = SEG_I;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!valid_o || code_o != 4'd4) drop++;
    end
    checks++;
    if (drop !== 0) begin errors++; $display("FAIL b2b_frozen got %0d changed cycles want 0", drop); end
    ready_i = 1'b1;
    tick();
    checks++;
    if (valid_o !== 1'b1 || code_o !== 4'd8) begin
      errors++; $display("FAIL b2b_second got valid=%b code=%0d want valid=1 code=8", valid_o, code_o);
    end
    tick();
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_release got %b want 0", valid_o); end
    ready_i = 1'b0;
  endtask

  task automatic test_reset_hold();
    int early;
    early = 0;
    seg_i = SEG_BLANK;
    for (int i = 0; i < 6; i++) tick();
    seg_i = SEG_A;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (valid_o !== 1'b1) begin errors++; $display("FAIL rsthold_pre got %b want 1", valid_o); end
    rst_ni = 1'b0;
    tick();
    checks++;
    if (valid_o !== 1'b0 || code_o !== 4'd0 || err_o !== 1'b0) begin
      errors++; $display("FAIL rsthold_clear got valid=%b code=%0d err=%b want 0 0 0", valid_o, code_o, err_o);
    end
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (valid_o) early++;
    end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL rsthold_early got %0d valid cycles want 0", early); end
    tick();
    checks++;
    if (valid_o !== 1'b1 || code_o !== 4'd0) begin
      errors++; $display("FAIL rsthold_redeliver got valid=%b code=%0d want valid=1 code=0", valid_o, code_o);
    end
  endtask

`ifdef A2I7SEG_RX_ERRCNT_EN
  task automatic test_errcnt_saturate();
    int pulses;
    pulses = 0;
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    for (int i = 0; i < 300; i++) begin
      seg_i = (i % 2 == 0) ? 7'b1010101 : 7'b0101010;
      for (int j = 0; j < 5; j++) begin
        tick();
        if (err_o) pulses++;
      end
    end
    checks++;
    if (pulses !== 300) begin errors++; $display("FAIL errcnt_pulses got %0d want 300", pulses); end
    checks++;
    if (err_cnt_o !== 8'd255) begin errors++; $display("FAIL errcnt_sat got %0d want 255", err_cnt_o); end
  endtask
`endif

  initial begin
    checks  = 0;
    errors  = 0;
    rst_ni  = 1'b0;
    seg_i   = SEG_BLANK;
    ready_i = 1'b0;
    test_reset();
    test_letter_a();
    test_unstable();
    test_rearm();
    test_error();
    test_back_to_back();
    test_reset_hold();
`ifdef A2I7SEG_RX_ERRCNT_EN
    test_errcnt_saturate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
